frame_capture_ctrl: RTL and testbench

Sequences camera pixel capture into the 320x240 frame buffer. It supports single-shot and continuous capture, and always starts a capture on a clean frame boundary. It produces the buffer write strobe, address and data, and flags short or overlong frames. It sits between the camera pixel interface (already synchronised to CLK25) and the frame buffer write port.

---
 rtl/frame_pkg.sv | 25 ++
 rtl/frame_capture_ctrl_if.sv | 36 +++
 rtl/frame_pix_counter.sv | 33 +++
 rtl/frame_capture_ctrl.sv | 129 ++++++++++++
 tb/tb_frame_capture_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// Shared frame geometry, bus widths and capture state encoding used by the
// capture and display sides of the frame buffer.
package frame_pkg;

  localparam int unsigned FRAME_W      = 320;
  localparam int unsigned FRAME_H      = 240;
  localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int unsigned ADDR_W       = 17;
  localparam int unsigned PIX_W        = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_START,
    ST_CAPTURE,
    ST_DONE
  } cap_state_t;

  // One frame buffer write beat
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } fb_wr_t;

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Camera pixel input, capture control, frame buffer write port and status of
// the capture controller. slave = controller side, master = driving side.
interface frame_capture_ctrl_if;
  import frame_pkg::*;

  logic              cam_vsync;
  logic              cam_pix_valid;
  logic [PIX_W-1:0]  cam_pix_data;
  logic              snap_req;
  logic              cont_mode;
  logic              abort;
  logic              clr_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              busy;
  logic              frame_done;
  logic              short_err;
  logic              ovf_err;
  logic [7:0]        frame_count;

  modport slave (
    input  cam_vsync, cam_pix_valid, cam_pix_data,
    input  snap_req, cont_mode, abort, clr_err,
    output wr_en, wr_addr, wr_data,
    output busy, frame_done, short_err, ovf_err, frame_count
  );

  modport master (
    output cam_vsync, cam_pix_valid, cam_pix_data,
    output snap_req, cont_mode, abort, clr_err,
    input  wr_en, wr_addr, wr_data,
    input  busy, frame_done, short_err, ovf_err, frame_count
  );

endinterface

// File: rtl/frame_pix_counter.sv
// Saturating pixel counter: sync clear, increment enable, flag at LIMIT.
module frame_pix_counter
  import frame_pkg::*;
#(
  parameter int unsigned LIMIT = FRAME_PIXELS
) (
  input  logic              CLK25,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_at_limit_c
);

  logic [ADDR_W-1:0] r_count;
  logic              w_at_limit;

  assign w_at_limit   = (r_count == ADDR_W'(LIMIT));
  assign o_at_limit_c = w_at_limit;
  assign o_count      = r_count;

  // Holds at LIMIT so extra pixels can never wrap back onto address 0
  always_ff @(posedge CLK25) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_limit) begin
      r_count <= r_count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Sequences camera pixels into the frame buffer: single-shot or continuous
// capture aligned to frame boundaries, with short/overlong frame flags.
module frame_capture_ctrl
  import frame_pkg::*;
#(
  parameter int unsigned H_ACTIVE = FRAME_W,
  parameter int unsigned V_ACTIVE = FRAME_H
) (
  input  logic                 CLK25,
  input  logic                 rst_n,
  frame_capture_ctrl_if.slave  io_cap
);

  localparam int unsigned PIXELS = H_ACTIVE * V_ACTIVE;

  cap_state_t        r_state;
  cap_state_t        w_state_nxt;
  logic              w_pix_wr;
  logic              w_cnt_clr;
  logic              w_short_set;
  logic              w_ovf_set;
  logic [ADDR_W-1:0] w_count;
  logic              w_at_limit;

  fb_wr_t            r_wr;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_short_err;
  logic              r_ovf_err;
  logic [7:0]        r_frame_count;

  frame_pix_counter #(
    .LIMIT (PIXELS)
  ) u_pix_counter (
    .CLK25        (CLK25),
    .rst_n        (rst_n),
    .i_clr        (w_cnt_clr),
    .i_inc        (w_pix_wr),
    .o_count      (w_count),
    .o_at_limit_c (w_at_limit)
  );

  always_ff @(posedge CLK25) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle strobes; vsync low wins over a coincident pixel
  always_comb begin
    w_state_nxt = r_state;
    w_pix_wr    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_short_set = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_cap.snap_req || io_cap.cont_mode) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (!io_cap.cam_vsync) w_state_nxt = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        w_cnt_clr = 1'b1;
        if (io_cap.cam_vsync) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!io_cap.cam_vsync) begin
          w_state_nxt = ST_DONE;
          w_short_set = !w_at_limit;
        end else if (io_cap.cam_pix_valid) begin
          w_ovf_set = w_at_limit;
          w_pix_wr  = !w_at_limit;
        end
      end
      ST_DONE: begin
        w_state_nxt = io_cap.cont_mode ? ST_WAIT_START : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (io_cap.abort) begin
      w_state_nxt = ST_IDLE;
      w_pix_wr    = 1'b0;
      w_short_set = 1'b0;
      w_ovf_set   = 1'b0;
    end
  end

  // Registered write port and status; busy/frame_done track the next state
  always_ff @(posedge CLK25) begin
    if (!rst_n) begin
      r_wr          <= '0;
      r_wr_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_short_err   <= 1'b0;
      r_ovf_err     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_wr_en      <= w_pix_wr;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= (w_state_nxt == ST_DONE);
      if (w_pix_wr) begin
        r_wr.addr <= w_count;
        r_wr.data <= io_cap.cam_pix_data;
      end
      if (r_state == ST_DONE && !io_cap.abort) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
      if (w_short_set)         r_short_err <= 1'b1;
      else if (io_cap.clr_err) r_short_err <= 1'b0;
      if (w_ovf_set)           r_ovf_err   <= 1'b1;
      else if (io_cap.clr_err) r_ovf_err   <= 1'b0;
    end
  end

  assign io_cap.wr_en       = r_wr_en;
  assign io_cap.wr_addr     = r_wr.addr;
  assign io_cap.wr_data     = r_wr.data;
  assign io_cap.busy        = r_busy;
  assign io_cap.frame_done  = r_frame_done;
  assign io_cap.short_err   = r_short_err;
  assign io_cap.ovf_err     = r_ovf_err;
  assign io_cap.frame_count = r_frame_count;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl on a reduced 8x4 frame; a write
// monitor checks every buffer write against the expected address/data order.
module tb_frame_capture_ctrl;
  import frame_pkg::*;

  localparam int unsigned TB_H   = 8;
  localparam int unsigned TB_V   = 4;
  localparam int          TB_PIX = TB_H * TB_V;

  localparam int EV_NONE      = 0;
  localparam int EV_SNAP      = 1;
  localparam int EV_ABORT     = 2;
  localparam int EV_CONT_DROP = 3;
  localparam int EV_RESET     = 4;

  logic CLK25 = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   exp_addr = 0;
  int   n_wr   = 0;
  int   n_done = 0;

  always #20 CLK25 = ~CLK25;

  frame_capture_ctrl_if u_if ();

  frame_capture_ctrl #(
    .H_ACTIVE (TB_H),
    .V_ACTIVE (TB_V)
  ) u_dut (
    .CLK25  (CLK25),
    .rst_n  (rst_n),
    .io_cap (u_if.slave)
  );

  function automatic logic [PIX_W-1:0] pix(input int i);
    return PIX_W'(i * 37 + 11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK25);
    #1;
  endtask

  task automatic blank(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wr_en"},       32'(u_if.wr_en),       0);
    chk({tag, ".wr_addr"},     32'(u_if.wr_addr),     0);
    chk({tag, ".wr_data"},     32'(u_if.wr_data),     0);
    chk({tag, ".busy"},        32'(u_if.busy),        0);
    chk({tag, ".frame_done"},  32'(u_if.frame_done),  0);
    chk({tag, ".short_err"},   32'(u_if.short_err),   0);
    chk({tag, ".ovf_err"},     32'(u_if.ovf_err),     0);
    chk({tag, ".frame_count"}, 32'(u_if.frame_count), 0);
  endtask

  // Monitor: every write must hit the next sequential address with its pixel
  always @(negedge CLK25) begin
    if (u_if.wr_en) begin
      chk("wr_addr", 32'(u_if.wr_addr), 32'(exp_addr));
      chk("wr_data", 32'(u_if.wr_data), 32'(pix(exp_addr)));
      exp_addr++;
      n_wr++;
    end
    if (u_if.frame_done) n_done++;
  end

  task automatic arm_snap();
    u_if.snap_req = 1'b1;
    tick();
    u_if.snap_req = 1'b0;
    blank(2);
  endtask

  // One frame: porch, npix pixels, then the vsync fall cycle; returns one
  // cycle after the fall edge (DONE visible if a capture ended)
  task automatic send_frame(input int npix, input int ev, input int ev_at,
                            input bit fall_pix, input bit fall_clr);
    exp_addr = 0;
    n_wr     = 0;
    u_if.cam_vsync = 1'b1;
    tick();
    for (int i = 0; i < npix; i++) begin
      u_if.cam_pix_valid = 1'b1;
      u_if.cam_pix_data  = pix(i);
      if (i == ev_at) begin
        case (ev)
          EV_SNAP:      u_if.snap_req  = 1'b1;
          EV_ABORT:     u_if.abort     = 1'b1;
          EV_CONT_DROP: u_if.cont_mode = 1'b0;
          EV_RESET:     rst_n          = 1'b0;
          default: ;
        endcase
      end
      tick();
      u_if.snap_req = 1'b0;
      u_if.abort    = 1'b0;
      if (ev == EV_RESET && i == ev_at) begin
        chk_zero("midrst");
        rst_n = 1'b1;
      end
    end
    u_if.cam_vsync     = 1'b0;
    u_if.cam_pix_valid = fall_pix;
    u_if.cam_pix_data  = pix(npix);
    u_if.clr_err       = fall_clr;
    tick();
    u_if.cam_pix_valid = 1'b0;
    u_if.clr_err       = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    u_if.cam_vsync     = 1'b0;
    u_if.cam_pix_valid = 1'b0;
    u_if.cam_pix_data  = '0;
    u_if.snap_req      = 1'b0;
    u_if.cont_mode     = 1'b0;
    u_if.abort         = 1'b0;
    u_if.clr_err       = 1'b0;
    blank(2);
    chk_zero("reset");
    rst_n = 1'b1;
    blank(2);

    // Single shot requested mid-frame: that frame is skipped, next one captured
    send_frame(TB_PIX, EV_SNAP, 12, 1'b0, 1'b0);
    chk("t1.skip_wr",   32'(n_wr), 0);
    chk("t1.skip_done", 32'(u_if.frame_done), 0);
    chk("t1.armed",     32'(u_if.busy), 1);
    blank(3);
    send_frame(TB_PIX, EV_NONE, -1, 1'b0, 1'b0);
    chk("t1.done",      32'(u_if.frame_done), 1);
    chk("t1.n_wr",      32'(n_wr), 32'(TB_PIX));
    chk("t1.last_addr", 32'(u_if.wr_addr), 32'(TB_PIX - 1));
    tick();
    chk("t1.done_fall", 32'(u_if.frame_done), 0);
    chk("t1.busy",      32'(u_if.busy), 0);
    chk("t1.count",     32'(u_if.frame_count), 1);
    chk("t1.n_done",    32'(n_done), 1);
    chk("t1.short",     32'(u_if.short_err), 0);
    chk("t1.ovf",       32'(u_if.ovf_err), 0);

    // Overlong frame: extra pixels dropped, overflow flagged
    arm_snap();
    send_frame(TB_PIX + 5, EV_NONE, -1, 1'b0, 1'b0);
    chk("t2.done",      32'(u_if.frame_done), 1);
    chk("t2.n_wr",      32'(n_wr), 32'(TB_PIX));
    chk("t2.last_addr", 32'(u_if.wr_addr), 32'(TB_PIX - 1));
    chk("t2.ovf",       32'(u_if.ovf_err), 1);
    chk("t2.short",     32'(u_if.short_err), 0);
    tick();
    chk("t2.count",     32'(u_if.frame_count), 2);
    chk("t2.n_done",    32'(n_done), 2);

    // Short frame, clr_err coincident with the short set: set wins
    arm_snap();
    send_frame(10, EV_NONE, -1, 1'b0, 1'b1);
    chk("t3.done",      32'(u_if.frame_done), 1);
    chk("t3.n_wr",      32'(n_wr), 10);
    chk("t3.short",     32'(u_if.short_err), 1);
    chk("t3.ovf_clr",   32'(u_if.ovf_err), 0);
    tick();
    chk("t3.count",     32'(u_if.frame_count), 3);
    u_if.clr_err = 1'b1;
    tick();
    u_if.clr_err = 1'b0;
    chk("t3.short_clr", 32'(u_if.short_err), 0);
    chk("t3.ovf_clr2",  32'(u_if.ovf_err), 0);

    // Continuous mode: three back-to-back frames, drop cont during the third
    u_if.cont_mode = 1'b1;
    blank(3);
    for (int f = 0; f < 3; f++) begin
      send_frame(TB_PIX, (f == 2) ? EV_CONT_DROP : EV_NONE, 20, 1'b0, 1'b0);
      chk("t4.done", 32'(u_if.frame_done), 1);
      chk("t4.n_wr", 32'(n_wr), 32'(TB_PIX));
      tick();
      chk("t4.busy",  32'(u_if.busy), (f < 2) ? 32'd1 : 32'd0);
      chk("t4.count", 32'(u_if.frame_count), 32'(4 + f));
      blank(2);
    end
    chk("t4.n_done", 32'(n_done), 6);
    chk("t4.short",  32'(u_if.short_err), 0);

    // Abort mid-frame, then a fresh capture restarts at address 0
    arm_snap();
    send_frame(TB_PIX, EV_ABORT, 10, 1'b0, 1'b0);
    chk("t5.n_wr",   32'(n_wr), 10);
    chk("t5.done",   32'(u_if.frame_done), 0);
    chk("t5.busy",   32'(u_if.busy), 0);
    chk("t5.count",  32'(u_if.frame_count), 6);
    chk("t5.n_done", 32'(n_done), 6);
    chk("t5.short",  32'(u_if.short_err), 0);
    arm_snap();
    send_frame(TB_PIX, EV_NONE, -1, 1'b0, 1'b0);
    chk("t5.re_n_wr", 32'(n_wr), 32'(TB_PIX));
    tick();
    chk("t5.re_count", 32'(u_if.frame_count), 7);

    // snap_req during capture ignored; pixel on the vsync fall not written
    arm_snap();
    send_frame(TB_PIX, EV_SNAP, 5, 1'b1, 1'b0);
    chk("t6.n_wr",  32'(n_wr), 32'(TB_PIX));
    chk("t6.ovf",   32'(u_if.ovf_err), 0);
    chk("t6.done",  32'(u_if.frame_done), 1);
    tick();
    chk("t6.count", 32'(u_if.frame_count), 8);
    blank(4);
    chk("t6.no_queue", 32'(u_if.busy), 0);

    // Reset asserted mid-capture
    arm_snap();
    send_frame(TB_PIX, EV_RESET, 15, 1'b0, 1'b0);
    chk("t6.rst_n_wr", 32'(n_wr), 15);
    chk("t6.rst_done", 32'(u_if.frame_done), 0);
    chk("t6.rst_busy", 32'(u_if.busy), 0);
    chk("t6.rst_cnt",  32'(u_if.frame_count), 0);
    blank(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
